monolith_job_arbiter: RTL and testbench
=======================================

Name: monolith_job_arbiter

Overview:
- Shares one Monolith M31 hash core between NUM_REQ requesters using round-robin arbitration.
- Sequences the core: canonicalises operands, pulses start, waits for a fresh valid, then returns the digest to the granted requester.
- A watchdog aborts hung jobs and returns an error response.
- Sits between the requester fabric (AXI-lite register slices, DMA) and the monolith core, replacing direct software writes of the start bit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 31, M31 field element width
- TIMEOUT_CYCLES, 1024, max cycles from start to core_valid before abort
- CNT_W, 16, width of completed-job counter

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester job request
- req_ready  out  NUM_REQ  one-hot accept, asserted for the grant cycle only
- req_in0  in  NUM_REQ*DATA_W  first operand per requester, packed, requester i at [i*DATA_W +: DATA_W]
- req_in1  in  NUM_REQ*DATA_W  second operand per requester, packed
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  DATA_W  digest, shared bus, meaningful while any rsp_valid is high
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- core_in0  out  DATA_W  operand 0 to core
- core_in1  out  DATA_W  operand 1 to core
- core_start  out  1  one-cycle start pulse
- core_valid  in  1  core result valid (level)
- core_out  in  DATA_W  core digest
- busy  out  1  high in any state except IDLE
- jobs_done  out  CNT_W  count of completed non-error jobs, wraps

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - core_in0 = 0, core_in1 = 0, core_start = 0.
  - busy = 0, jobs_done = 0.
  - rr_ptr = 0, state = IDLE.
- Reset mid-job drops the job silently. No response is issued; the core is not signalled.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req_valid != 0, grant the first set bit at or after rr_ptr, searching cyclically.
  - Assert req_ready[g] for that cycle and latch operands and the grant index.
  - Set rr_ptr = (g+1) mod NUM_REQ, then go to ISSUE.
- Canonicalisation on latch: an operand equal to 2^31-1 is stored as 0. All other values pass unchanged.
- ISSUE:
  - core_start = 1 for exactly one cycle; core_in0/core_in1 are driven from the latched operands and held stable until RESP exits.
  - Clear seen_low, load the watchdog with TIMEOUT_CYCLES, go to WAIT.
- WAIT:
  - core_valid may still be high from a previous job, so it is ignored until it has been sampled low at least once (seen_low).
  - Once seen_low = 1 and core_valid = 1: capture core_out into rsp_data, set rsp_err = 0, go to RESP.
  - Watchdog decrements each WAIT cycle. On reaching 0 before a fresh valid: rsp_data = 0, rsp_err = 1, go to RESP.
  - If fresh valid and watchdog expiry fall in the same cycle, valid wins: rsp_err = 0.
- RESP:
  - rsp_valid[g] = 1, held with rsp_data/rsp_err stable until rsp_ready[g] = 1.
  - On handshake: drop rsp_valid; increment jobs_done if not err (wraps 2^CNT_W-1 to 0); return to IDLE.
  - rsp_ready from non-granted requesters is ignored.
- Throughput: one job in flight.
- Latency: grant to start = 1 cycle; core done to rsp_valid = 1 cycle.
- A new grant occurs in the cycle after the RESP handshake, never in the same cycle.
- Requests arriving in non-IDLE states wait. req_valid must hold until req_ready; dropping it earlier is legal and simply forfeits the grant.
- busy = (state != IDLE).

Decomposition:
- Package monolith_pkg holds:
  - M31_P = 31'h7FFFFFFF
  - DATA_W
  - enum arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - function m31_canon()
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick from req_valid and rr_ptr, returning a one-hot grant and an index. The FSM, watchdog and counters stay in the top module.

Test Plan:
- Single job: requester 0 sends in0 = 0x610300a3, in1 = 0; core model returns 0x1234567 after 40 cycles -> exactly one core_start, rsp_valid[0] = 1 with rsp_data = 0x1234567, rsp_err = 0, jobs_done = 1.
- Fairness: all 4 requesters hold req_valid continuously, rr_ptr = 0 -> grant order 0,1,2,3,0; no requester granted twice before the others.
- Stale valid: core_valid held high from the previous job and lowered 3 cycles after core_start -> the response uses the later fresh valid, not the stale one.
- Timeout: TIMEOUT_CYCLES = 16, core never asserts valid -> rsp_err = 1, rsp_data = 0 after 16 WAIT cycles; jobs_done unchanged; next job proceeds normally.
- Canonicalisation: in0 = 0x7FFFFFFF, in1 = 5 -> core_in0 = 0, core_in1 = 5 at core_start.
- Backpressure + reset:
  - rsp_ready[1] held low for 10 cycles -> rsp_valid/rsp_data stable, no new grant.
  - Reset asserted in WAIT -> all outputs return to reset values within the same cycle (asynchronous), with no response issued.

Source files
------------

// File: rtl/monolith_pkg.sv
// Shared types and helpers for the Monolith M31 job arbiter.
// Pure declarations: no logic, no latency, no flow control.
package monolith_pkg;

    localparam int DATA_W = 31;
    localparam logic [DATA_W-1:0] M31_P = 31'h7FFFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // p itself is congruent to zero, so it is folded to the canonical 0.
    function automatic logic [DATA_W-1:0] m31_canon(input logic [DATA_W-1:0] x);
        return (x == M31_P) ? '0 : x;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, cyclically.
// Zero latency; no backpressure, vld_o is low when nothing requests.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!vld_o && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                vld_o = 1'b1;
                idx_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
                gnt_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/monolith_job_arbiter.sv
// Round-robin sharing of one Monolith core: grant, start pulse, wait for fresh valid, respond.
// Grant->start 1 cycle, core done->rsp_valid 1 cycle; response held until the granted rsp_ready.
module monolith_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 31,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_in0,
    input  logic [NUM_REQ*DATA_W-1:0]   req_in1,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           core_in0,
    output logic [DATA_W-1:0]           core_in1,
    output logic                        core_start,
    input  logic                        core_valid,
    input  logic [DATA_W-1:0]           core_out,
    output logic                        busy,
    output logic [CNT_W-1:0]            jobs_done
);

    import monolith_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [DATA_W-1:0]   op0_q, op0_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                seen_low_q, seen_low_d;
    logic [CNT_W-1:0]    jobs_done_q, jobs_done_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        op0_d       = op0_q;
        op1_d       = op1_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        wdog_d      = wdog_q;
        seen_low_d  = seen_low_q;
        jobs_done_d = jobs_done_q;
        req_ready   = '0;
        rsp_valid   = '0;
        core_start  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    req_ready = arb_gnt;
                    gnt_d     = arb_idx;
                    op0_d     = m31_canon(req_in0[int'(arb_idx)*DATA_W +: DATA_W]);
                    op1_d     = m31_canon(req_in1[int'(arb_idx)*DATA_W +: DATA_W]);
                    rr_ptr_d  = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                seen_low_d = 1'b0;
                wdog_d     = WD_W'(TIMEOUT_CYCLES);
                state_d    = WAIT;
            end
            WAIT: begin
                // A level left high by the previous job must not complete this one.
                if (!core_valid) begin
                    seen_low_d = 1'b1;
                end
                if (seen_low_q && core_valid) begin
                    rsp_data_d = core_out;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (wdog_q <= WD_W'(1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    wdog_d = wdog_q - 1'b1;
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    if (!rsp_err_q) begin
                        jobs_done_d = jobs_done_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            op0_q       <= '0;
            op1_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            wdog_q      <= '0;
            seen_low_q  <= 1'b0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            wdog_q      <= wdog_d;
            seen_low_q  <= seen_low_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign core_in0  = op0_q;
    assign core_in1  = op1_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_monolith_job_arbiter.sv
// Directed self-checking bench for monolith_job_arbiter; the core is driven step by step.
// Watchdog is 48 cycles so a 40-cycle core job fits and a timeout stays short.
module tb_monolith_job_arbiter;

    localparam int NR = 4;
    localparam int DW = 31;
    localparam int TO = 48;
    localparam int CW = 16;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_in0;
    logic [NR*DW-1:0]  req_in1;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic [DW-1:0]     core_in0;
    logic [DW-1:0]     core_in1;
    logic              core_start;
    logic              core_valid;
    logic [DW-1:0]     core_out;
    logic              busy;
    logic [CW-1:0]     jobs_done;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int n0;
    logic [NR-1:0] oh;

    monolith_job_arbiter #(
        .NUM_REQ        (NR),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in0    (req_in0),
        .req_in1    (req_in1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .core_in0   (core_in0),
        .core_in1   (core_in1),
        .core_start (core_start),
        .core_valid (core_valid),
        .core_out   (core_out),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (core_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic set_ops(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_in0[r*DW +: DW] = a;
        req_in1[r*DW +: DW] = b;
    endtask

    // Called in the ISSUE cycle; raises core_valid after lat cycles and ends in RESP.
    task automatic run_core(input int lat, input logic [DW-1:0] d);
        core_valid = 1'b0;
        tick(lat);
        core_valid = 1'b1;
        core_out   = d;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1; req_valid = '0; rsp_ready = '0;
        core_valid = 1'b0; core_out = '0; req_in0 = '0; req_in1 = '0;
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_core_in0", core_in0, 0);
        chk("rst_core_in1", core_in1, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobs_done", jobs_done, 0);
        tick(2); reset = 1'b0; tick(1);

        // Single job from requester 0, 40-cycle core
        set_ops(0, 31'h610300a3, 31'h0);
        req_valid = 4'b0001; #1;
        chk("j1_req_ready", req_ready, 4'b0001);
        n0 = start_cnt;
        tick(1); req_valid = '0;
        chk("j1_core_start", core_start, 1);
        chk("j1_core_in0", core_in0, 31'h610300a3);
        chk("j1_core_in1", core_in1, 0);
        chk("j1_busy", busy, 1);
        run_core(40, 31'h1234567);
        chk("j1_rsp_valid", rsp_valid, 4'b0001);
        chk("j1_rsp_data", rsp_data, 31'h1234567);
        chk("j1_rsp_err", rsp_err, 0);
        rsp_ready = 4'b0001; tick(1); rsp_ready = '0;
        chk("j1_rsp_drop", rsp_valid, 0);
        chk("j1_jobs_done", jobs_done, 1);
        chk("j1_idle", busy, 0);
        chk("j1_one_start", start_cnt - n0, 1);

        reset = 1'b1; tick(1);
        chk("rst2_jobs_done", jobs_done, 0);
        reset = 1'b0; tick(1);

        // Fairness: all requesters hold req_valid, rr_ptr starts at 0
        for (int r = 0; r < NR; r++) set_ops(r, DW'(32'h10 + r), DW'(32'h20 + r));
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            #1;
            chk("fair_grant", req_ready, oh);
            tick(1);
            chk("fair_core_in0", core_in0, 32'h10 + (k % 4));
            run_core(2, DW'(32'h100 + k));
            chk("fair_rsp_valid", rsp_valid, oh);
            chk("fair_rsp_data", rsp_data, 32'h100 + k);
            rsp_ready = 4'hF; tick(1); rsp_ready = '0;
        end
        req_valid = '0;
        chk("fair_jobs_done", jobs_done, 5);

        // Stale valid: core_valid still high from the last job, lowered 3 cycles after start
        set_ops(2, 31'h222, 31'h333);
        req_valid = 4'b0100; #1;
        chk("stale_grant", req_ready, 4'b0100);
        tick(1); req_valid = '0;
        tick(3); core_valid = 1'b0;
        chk("stale_ignored", rsp_valid, 0);
        chk("stale_busy", busy, 1);
        tick(2);
        core_valid = 1'b1; core_out = 31'h0ABCDEF;
        tick(1);
        chk("stale_rsp_valid", rsp_valid, 4'b0100);
        chk("stale_rsp_data", rsp_data, 31'h0ABCDEF);
        rsp_ready = 4'b0100; tick(1); rsp_ready = '0;
        chk("stale_jobs_done", jobs_done, 6);

        // Canonicalisation on in0, then backpressure on requester 1
        set_ops(1, 31'h7FFFFFFF, 31'd5);
        req_valid = 4'b0010; #1;
        chk("canon_grant", req_ready, 4'b0010);
        tick(1); req_valid = '0;
        chk("canon_start", core_start, 1);
        chk("canon_core_in0", core_in0, 0);
        chk("canon_core_in1", core_in1, 5);
        run_core(3, 31'h55AA55A);
        rsp_ready = 4'b1101; req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp_valid", rsp_valid, 4'b0010);
            chk("bp_rsp_data", rsp_data, 31'h55AA55A);
            chk("bp_no_grant", req_ready, 0);
            tick(1);
        end
        chk("bp_still_held", rsp_valid, 4'b0010);
        rsp_ready = 4'b0010; tick(1); rsp_ready = '0;
        chk("bp_jobs_done", jobs_done, 7);
        chk("bp_idle", busy, 0);
        chk("bp_next_grant", req_ready, 4'b0001);

        // Timeout: core never responds to requester 0
        tick(1); req_valid = '0; core_valid = 1'b0;
        tick(TO);
        chk("to_not_early", rsp_valid, 0);
        chk("to_busy", busy, 1);
        tick(1);
        chk("to_rsp_valid", rsp_valid, 4'b0001);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_data", rsp_data, 0);
        rsp_ready = 4'b0001; tick(1); rsp_ready = '0;
        chk("to_jobs_same", jobs_done, 7);

        // Next job after timeout, canonicalising in1
        set_ops(3, 31'h12345, 31'h7FFFFFFF);
        req_valid = 4'b1000; #1;
        chk("post_to_grant", req_ready, 4'b1000);
        tick(1); req_valid = '0;
        chk("post_to_in0", core_in0, 31'h12345);
        chk("post_to_in1", core_in1, 0);
        run_core(5, 31'h7654321);
        chk("post_to_rsp_valid", rsp_valid, 4'b1000);
        chk("post_to_rsp_err", rsp_err, 0);
        chk("post_to_rsp_data", rsp_data, 31'h7654321);
        rsp_ready = 4'b1000; tick(1); rsp_ready = '0;
        chk("post_to_jobs", jobs_done, 8);

        // Fresh valid in the same cycle the watchdog expires: valid wins
        req_valid = 4'b0001; tick(1); req_valid = '0;
        run_core(TO, 31'h0C0FFEE);
        chk("tie_rsp_valid", rsp_valid, 4'b0001);
        chk("tie_rsp_err", rsp_err, 0);
        chk("tie_rsp_data", rsp_data, 31'h0C0FFEE);
        rsp_ready = 4'b0001; tick(1); rsp_ready = '0;
        chk("tie_jobs", jobs_done, 9);

        // Asynchronous reset while in WAIT
        set_ops(2, 31'h777, 31'h888);
        req_valid = 4'b0100; tick(1); req_valid = '0;
        core_valid = 1'b0;
        tick(2);
        chk("arst_pre_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_core_in0", core_in0, 0);
        chk("arst_core_in1", core_in1, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_core_start", core_start, 0);
        chk("arst_jobs_done", jobs_done, 0);
        tick(2); reset = 1'b0; tick(3);
        chk("arst_no_rsp", rsp_valid, 0);
        chk("arst_idle", busy, 0);
        chk("arst_no_grant", req_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
